apb3_completer_synth: RTL



---
 rtl/apb3_completer_synth.sv | 129 ++++++++++++
 1 files changed

// File: rtl/apb3_completer_synth.sv
// apb3_completer_synth
//   APB3 completer fronting a word-addressed register file. Each transfer is
//   latched in the setup phase, held for WaitStates access cycles with
//   pready=0, then completes with one pready cycle. Misaligned or
//   out-of-range addresses complete with pslverr=1 and have no side effects.
//
// Ports
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   paddr        APB3 byte address
//   psel         APB3 select
//   penable      APB3 enable (access phase)
//   pwrite       1 = write, 0 = read
//   pwdata       write data
//   pready       transfer complete (one cycle per transfer)
//   prdata       read data, non-zero only in the pready cycle of a legal read
//   pslverr      error response, only in the pready cycle of an illegal access
//   write_count  number of committed writes, wraps at 16 bits
module apb3_completer_synth #(
    parameter int unsigned          AddressWidth = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          RegCount     = 16,
    parameter int unsigned          WaitStates   = 0,
    parameter logic [DataWidth-1:0] ResetValue   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    output logic [15:0]             write_count
);

    localparam int unsigned IdxWidth = $clog2(RegCount);
    // One extra bit so RegCount*4 never truncates against a narrow paddr.
    localparam logic [AddressWidth:0] ByteLimit = (AddressWidth + 1)'(RegCount * 4);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DataWidth-1:0]  regs_q [RegCount];
    logic [15:0]           wcount_q;
    logic                  addr_err;
    logic                  commit;

    // Range compare covers every upper address bit, so nothing aliases.
    assign addr_err = (paddr[1:0] != 2'b00) || ({1'b0, paddr} >= ByteLimit);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // penable=1 while idle is a protocol violation and is ignored.
                if (psel && !penable) begin
                    state_d = StAccess;
                    idx_d   = paddr[2 +: IdxWidth];
                    write_d = pwrite;
                    wdata_d = pwdata;
                    err_d   = addr_err;
                    cnt_d   = 4'(WaitStates);
                end
            end
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                    commit  = penable && write_q && !err_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RegCount; i++) begin
                regs_q[i] <= ResetValue;
            end
            wcount_q <= 16'd0;
        end else if (commit) begin
            regs_q[idx_q] <= wdata_q;
            wcount_q      <= wcount_q + 16'd1;
        end
    end

    assign pready      = (state_q == StAccess) && (cnt_q == 4'd0);
    assign pslverr     = pready && err_q;
    // Register array is read before the commit edge, so same-cycle reads see old data.
    assign prdata      = (pready && !write_q && !err_q) ? regs_q[idx_q] : '0;
    assign write_count = wcount_q;

endmodule
